phase_sweep_nco: RTL and testbench
==================================

PHASE_SWEEP_NCO -- requirements
Module: phase_sweep_nco

Interface
REQ-001 Parameter: PHASE_BITS, default 47, phase/tuning-word width; matches the sine-stage phase input.
REQ-002 Parameter: LEN_BITS, default 32, width of the sweep sample count.
REQ-003 clk  input  1  clock; all logic rising-edge.
REQ-004 resetn  input  1  reset, asynchronous, active-low.
REQ-005 en_i  input  1  sample enable; one phase sample produced per RUN cycle with en_i=1.
REQ-006 start_i  input  1  pulse; latches configuration and begins a sweep.
REQ-007 abort_i  input  1  pulse; terminates any sweep.
REQ-008 ftw_start_i  input  PHASE_BITS  initial frequency tuning word, unsigned.
REQ-009 ftw_step_i  input  PHASE_BITS  per-sample FTW increment, two's complement.
REQ-010 phase_off_i  input  PHASE_BITS  initial phase.
REQ-011 len_i  input  LEN_BITS  samples per sweep; 0 = continuous.
REQ-012 valid_o  output  1  phase_o carries a sample; drives the sine stage valid_i.
REQ-013 phase_o  output  PHASE_BITS  registered phase sample.
REQ-014 busy_o  output  1  high in RUN.
REQ-015 done_o  output  1  one-cycle pulse at sweep completion or abort.

Function
REQ-016 States IDLE, RUN; state register, accumulators and outputs all registered.
REQ-017 IDLE + start_i=1 (abort_i=0): latch step and len; acc<=phase_off_i; ftw<=ftw_start_i; cnt<=0; next state RUN.
REQ-018 RUN + en_i=1: valid_o<=1, phase_o<=acc, acc<=acc+ftw, ftw<=ftw+step, cnt<=cnt+1, all in one edge.
REQ-019 RUN + en_i=0: valid_o<=0; acc, ftw, cnt, phase_o held.
REQ-020 IDLE: valid_o<=0, phase_o held.
REQ-021 Latency: start_i sampled at edge k with en_i=1 at k+1 gives valid_o=1 and phase_o=phase_off_i after edge k+1.
REQ-022 Sum arithmetic modulo 2^PHASE_BITS: acc and ftw wrap silently, no saturation; step sign-extended to nothing (same width).
REQ-023 len!=0: on the edge emitting sample cnt=len-1, state<=IDLE and done_o<=1 on the same edge; exactly len samples emitted.
REQ-024 len=0: RUN until abort_i; cnt wraps modulo 2^LEN_BITS without effect.
REQ-025 abort_i=1 in RUN: state<=IDLE, valid_o<=0, done_o<=1; the sample in that cycle is not emitted.
REQ-026 abort_i=1 in IDLE: no effect, no done_o.
REQ-027 start_i and abort_i together: abort wins; start ignored.
REQ-028 start_i in RUN: ignored; configuration inputs sampled only on an accepted start.
REQ-029 busy_o=1 exactly while state=RUN.

Reset
REQ-030 resetn low: state=IDLE; acc, ftw, step, cnt, phase_o=0; valid_o, busy_o, done_o=0, immediately and asynchronously.
REQ-031 Reset mid-sweep discards the sweep; no done_o after release.

Configuration
REQ-032 Macro NCO_COS_EN defined: extra output phase_cos_o (PHASE_BITS), registered with phase_o, equal to phase_o + 2^(PHASE_BITS-2) modulo 2^PHASE_BITS (quarter turn, feeds a second sine stage as cosine), sharing valid_o.
REQ-033 NCO_COS_EN undefined: port and logic absent; other behaviour identical.

Structure
REQ-034 Package nco_pkg holds PHASE_BITS, LEN_BITS, QUARTER_TURN constant and the state enum type.
REQ-035 Sub-module nco_accum holds the acc/ftw accumulator pair with load and advance controls; the FSM, counter and outputs stay in phase_sweep_nco.

Verification
REQ-036 Fixed tone: ftw_start=2^40, step=0, off=0, len=4, en_i=1 -> phase_o 0, 2^40, 2*2^40, 3*2^40; done_o with 4th sample; busy_o low after.
REQ-037 Chirp: ftw_start=100, step=10, off=5, len=3 -> phase_o 5, 105, 215; 2 idle cycles later valid_o=0.
REQ-038 Wrap: off=2^47-1, ftw_start=2, len=2 -> phase_o 2^47-1, 1.
REQ-039 en_i gating: len=3 with en_i pattern 1,0,0,1,1 -> 3 valid samples, identical values to continuous run; done_o on 5th cycle.
REQ-040 Abort/start collision: len=0 run, assert start_i+abort_i together -> IDLE next cycle, done_o one pulse, valid_o 0.
REQ-041 Reset mid-sweep and NCO_COS_EN build: resetn low at sample 2 -> all outputs 0; with macro, phase_o=0 gives phase_cos_o=2^45.

Source files
------------

// File: rtl/nco_pkg.sv
// Shared constants and state type for the phase sweep NCO.
package nco_pkg;

  localparam int PHASE_BITS = 47;
  localparam int LEN_BITS   = 32;

  // Quarter of a full phase turn at the default width; the cosine output
  // is the sine phase advanced by this amount.
  localparam logic [PHASE_BITS-1:0] QUARTER_TURN = PHASE_BITS'(1) << (PHASE_BITS - 2);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } nco_state_e;

endpackage

// File: rtl/nco_accum.sv
// Phase accumulator and frequency accumulator pair.
// load_i seeds both registers; adv_i advances the phase by the current
// tuning word and the tuning word by the step, all modulo 2^PHASE_BITS.
module nco_accum #(
  parameter int PHASE_BITS = 47
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  load_i,
  input  logic                  adv_i,
  input  logic [PHASE_BITS-1:0] phase_off_i,
  input  logic [PHASE_BITS-1:0] ftw_start_i,
  input  logic [PHASE_BITS-1:0] step_i,
  output logic [PHASE_BITS-1:0] acc_o,
  output logic [PHASE_BITS-1:0] ftw_o
);

  logic [PHASE_BITS-1:0] acc_q, acc_d;
  logic [PHASE_BITS-1:0] ftw_q, ftw_d;

  // Next accumulator values: load has priority, otherwise advance or hold.
  always_comb begin
    acc_d = acc_q;
    ftw_d = ftw_q;
    if (load_i) begin
      acc_d = phase_off_i;
      ftw_d = ftw_start_i;
    end else if (adv_i) begin
      acc_d = acc_q + ftw_q;
      ftw_d = ftw_q + step_i;
    end
  end

  // Accumulator registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      acc_q <= '0;
      ftw_q <= '0;
    end else begin
      acc_q <= acc_d;
      ftw_q <= ftw_d;
    end
  end

  assign acc_o = acc_q;
  assign ftw_o = ftw_q;

endmodule

// File: rtl/phase_sweep_nco.sv
// Linear-chirp phase generator feeding a sine stage.
// Optional build macro NCO_COS_EN adds phase_cos_o, a quarter-turn
// shifted copy of phase_o for a second (cosine) sine stage.
//
// state   | meaning
// --------+--------------------------------------------------------
// ST_IDLE | waiting for start_i; outputs quiet, phase_o held
// ST_RUN  | emitting one phase sample per cycle with en_i high
module phase_sweep_nco
  import nco_pkg::*;
#(
  parameter int PHASE_BITS = nco_pkg::PHASE_BITS,
  parameter int LEN_BITS   = nco_pkg::LEN_BITS
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  en_i,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [PHASE_BITS-1:0] ftw_start_i,
  input  logic [PHASE_BITS-1:0] ftw_step_i,
  input  logic [PHASE_BITS-1:0] phase_off_i,
  input  logic [LEN_BITS-1:0]   len_i,
  output logic                  valid_o,
  output logic [PHASE_BITS-1:0] phase_o,
  output logic                  busy_o,
  output logic                  done_o
`ifdef NCO_COS_EN
  ,
  output logic [PHASE_BITS-1:0] phase_cos_o
`endif
);

  localparam logic [LEN_BITS-1:0] CNT_ONE = LEN_BITS'(1);

  nco_state_e            state_q, state_d;
  logic [PHASE_BITS-1:0] step_q, step_d;
  logic [LEN_BITS-1:0]   len_q, len_d;
  logic [LEN_BITS-1:0]   cnt_q, cnt_d;
  logic [PHASE_BITS-1:0] phase_q, phase_d;
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;

  logic                  acc_load;
  logic                  acc_adv;
  logic                  last_sample;
  logic [PHASE_BITS-1:0] acc;
  logic [PHASE_BITS-1:0] ftw;

  nco_accum #(
    .PHASE_BITS (PHASE_BITS)
  ) u_accum (
    .clk         (clk),
    .resetn      (resetn),
    .load_i      (acc_load),
    .adv_i       (acc_adv),
    .phase_off_i (phase_off_i),
    .ftw_start_i (ftw_start_i),
    .step_i      (step_q),
    .acc_o       (acc),
    .ftw_o       (ftw)
  );

  // A zero length means continuous, so it never reaches a last sample.
  assign last_sample = (len_q != '0) && (cnt_q == len_q - CNT_ONE);

  // Sweep control: abort beats everything, start is only honoured in IDLE.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    phase_d  = phase_q;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    acc_load = 1'b0;
    acc_adv  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i && !abort_i) begin
          acc_load = 1'b1;
          step_d   = ftw_step_i;
          len_d    = len_i;
          cnt_d    = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort_i) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else if (en_i) begin
          valid_d = 1'b1;
          phase_d = acc;
          acc_adv = 1'b1;
          cnt_d   = cnt_q + CNT_ONE;
          if (last_sample) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      phase_q <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign valid_o = valid_q;
  assign phase_o = phase_q;
  assign busy_o  = (state_q == ST_RUN);
  assign done_o  = done_q;

`ifdef NCO_COS_EN
  localparam logic [PHASE_BITS-1:0] COS_SHIFT = PHASE_BITS'(1) << (PHASE_BITS - 2);

  logic [PHASE_BITS-1:0] phase_cos_q, phase_cos_d;

  // Cosine phase tracks phase_o exactly, so its reset value is the shift itself.
  always_comb begin
    phase_cos_d = phase_d + COS_SHIFT;
  end

  // Cosine phase register, updated alongside phase_q.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      phase_cos_q <= COS_SHIFT;
    end else begin
      phase_cos_q <= phase_cos_d;
    end
  end

  assign phase_cos_o = phase_cos_q;
`endif

endmodule

// File: tb/tb_phase_sweep_nco.sv
// Directed bench for phase_sweep_nco (default widths 47/32).
module tb_phase_sweep_nco;

  localparam int PB = 47;
  localparam int LB = 32;

  localparam logic [PB-1:0] P40  = 47'h0100_0000_0000;
  localparam logic [PB-1:0] P45  = 47'h2000_0000_0000;
  localparam logic [PB-1:0] PMAX = 47'h7FFF_FFFF_FFFF;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          en_i = 1'b0;
  logic          start_i = 1'b0;
  logic          abort_i = 1'b0;
  logic [PB-1:0] ftw_start_i = '0;
  logic [PB-1:0] ftw_step_i = '0;
  logic [PB-1:0] phase_off_i = '0;
  logic [LB-1:0] len_i = '0;
  logic          valid_o;
  logic [PB-1:0] phase_o;
  logic          busy_o;
  logic          done_o;
`ifdef NCO_COS_EN
  logic [PB-1:0] phase_cos_o;
`endif

  int total = 0;
  int bad = 0;

  phase_sweep_nco #(
    .PHASE_BITS (PB),
    .LEN_BITS   (LB)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .en_i        (en_i),
    .start_i     (start_i),
    .abort_i     (abort_i),
    .ftw_start_i (ftw_start_i),
    .ftw_step_i  (ftw_step_i),
    .phase_off_i (phase_off_i),
    .len_i       (len_i),
    .valid_o     (valid_o),
    .phase_o     (phase_o),
    .busy_o      (busy_o),
    .done_o      (done_o)
`ifdef NCO_COS_EN
    ,
    .phase_cos_o (phase_cos_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_sweep(input logic [PB-1:0] ftw, input logic [PB-1:0] step,
                             input logic [PB-1:0] off, input logic [LB-1:0] len);
    ftw_start_i = ftw;
    ftw_step_i  = step;
    phase_off_i = off;
    len_i       = len;
    start_i     = 1'b1;
    tick();
    start_i     = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({valid_o, busy_o, done_o} !== 3'b000) begin
      bad++;
      $display("FAIL reset_flags got=%b want=000", {valid_o, busy_o, done_o});
    end
    total++;
    if (phase_o !== '0) begin
      bad++;
      $display("FAIL reset_phase got=%0d want=0", phase_o);
    end
`ifdef NCO_COS_EN
    total++;
    if (phase_cos_o !== P45) begin
      bad++;
      $display("FAIL reset_cos got=%0h want=%0h", phase_cos_o, P45);
    end
`endif
    #10;
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_fixed_tone();
    logic [PB-1:0] exp_ph [4];
    exp_ph[0] = '0;
    exp_ph[1] = P40;
    exp_ph[2] = 47'h0200_0000_0000;
    exp_ph[3] = 47'h0300_0000_0000;
    en_i = 1'b1;
    start_sweep(P40, '0, '0, 32'd4);
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (valid_o !== 1'b1 || phase_o !== exp_ph[i]) begin
        bad++;
        $display("FAIL tone_sample[%0d] got valid=%b phase=%0h want valid=1 phase=%0h",
                 i, valid_o, phase_o, exp_ph[i]);
      end
      total++;
      if (done_o !== (i == 3) || busy_o !== (i != 3)) begin
        bad++;
        $display("FAIL tone_ctrl[%0d] got done=%b busy=%b want done=%b busy=%b",
                 i, done_o, busy_o, (i == 3), (i != 3));
      end
`ifdef NCO_COS_EN
      total++;
      if (phase_cos_o !== exp_ph[i] + P45) begin
        bad++;
        $display("FAIL tone_cos[%0d] got=%0h want=%0h", i, phase_cos_o, exp_ph[i] + P45);
      end
`endif
    end
    tick();
    total++;
    if ({valid_o, busy_o, done_o} !== 3'b000 || phase_o !== exp_ph[3]) begin
      bad++;
      $display("FAIL tone_after got v/b/d=%b phase=%0h want 000 phase=%0h",
               {valid_o, busy_o, done_o}, phase_o, exp_ph[3]);
    end
  endtask

  task automatic test_chirp();
    logic [PB-1:0] exp_ph [3];
    exp_ph[0] = 47'd5;
    exp_ph[1] = 47'd105;
    exp_ph[2] = 47'd215;
    en_i = 1'b1;
    start_sweep(47'd100, 47'd10, 47'd5, 32'd3);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (valid_o !== 1'b1 || phase_o !== exp_ph[i] || done_o !== (i == 2)) begin
        bad++;
        $display("FAIL chirp[%0d] got valid=%b phase=%0d done=%b want 1 %0d %b",
                 i, valid_o, phase_o, done_o, exp_ph[i], (i == 2));
      end
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (valid_o !== 1'b0 || done_o !== 1'b0) begin
        bad++;
        $display("FAIL chirp_idle[%0d] got valid=%b done=%b want 0 0", i, valid_o, done_o);
      end
    end
  endtask

  task automatic test_wrap();
    en_i = 1'b1;
    start_sweep(47'd2, '0, PMAX, 32'd2);
    tick();
    total++;
    if (valid_o !== 1'b1 || phase_o !== PMAX) begin
      bad++;
      $display("FAIL wrap_s0 got valid=%b phase=%0h want 1 %0h", valid_o, phase_o, PMAX);
    end
`ifdef NCO_COS_EN
    total++;
    if (phase_cos_o !== 47'h1FFF_FFFF_FFFF) begin
      bad++;
      $display("FAIL wrap_cos got=%0h want=1fffffffffff", phase_cos_o);
    end
`endif
    tick();
    total++;
    if (valid_o !== 1'b1 || phase_o !== 47'd1 || done_o !== 1'b1) begin
      bad++;
      $display("FAIL wrap_s1 got valid=%b phase=%0h done=%b want 1 1 1", valid_o, phase_o, done_o);
    end
    tick();
  endtask

  task automatic test_en_gating();
    logic          en_pat [5];
    logic          exp_v  [5];
    logic [PB-1:0] exp_ph [5];
    en_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_v  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_ph = '{47'd5, 47'd5, 47'd5, 47'd105, 47'd215};
    en_i = 1'b0;
    start_sweep(47'd100, 47'd10, 47'd5, 32'd3);
    for (int i = 0; i < 5; i++) begin
      en_i = en_pat[i];
      tick();
      total++;
      if (valid_o !== exp_v[i] || phase_o !== exp_ph[i] || done_o !== (i == 4)) begin
        bad++;
        $display("FAIL gate[%0d] got valid=%b phase=%0d done=%b want %b %0d %b",
                 i, valid_o, phase_o, done_o, exp_v[i], exp_ph[i], (i == 4));
      end
    end
    en_i = 1'b1;
    tick();
    total++;
    if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
      bad++;
      $display("FAIL gate_end got busy=%b valid=%b want 0 0", busy_o, valid_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [PB-1:0] exp_ph [4];
    exp_ph = '{47'd5, 47'd105, 47'd215, 47'd335};
    en_i = 1'b1;
    start_sweep(47'd100, 47'd10, 47'd5, 32'd0);
    for (int i = 0; i < 4; i++) begin
      // A start while running must not reload configuration.
      if (i == 1) begin
        start_i     = 1'b1;
        ftw_start_i = 47'd999;
        phase_off_i = 47'd777;
        ftw_step_i  = 47'd1;
      end else begin
        start_i = 1'b0;
      end
      tick();
      total++;
      if (valid_o !== 1'b1 || phase_o !== exp_ph[i] || busy_o !== 1'b1 || done_o !== 1'b0) begin
        bad++;
        $display("FAIL cont[%0d] got v=%b ph=%0d busy=%b done=%b want 1 %0d 1 0",
                 i, valid_o, phase_o, busy_o, done_o, exp_ph[i]);
      end
    end
    start_i = 1'b1;
    abort_i = 1'b1;
    tick();
    start_i = 1'b0;
    abort_i = 1'b0;
    total++;
    if ({valid_o, busy_o, done_o} !== 3'b001 || phase_o !== 47'd335) begin
      bad++;
      $display("FAIL abort_edge got v/b/d=%b ph=%0d want 001 335", {valid_o, busy_o, done_o}, phase_o);
    end
    tick();
    total++;
    if ({valid_o, busy_o, done_o} !== 3'b000) begin
      bad++;
      $display("FAIL abort_after got v/b/d=%b want 000", {valid_o, busy_o, done_o});
    end
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    total++;
    if ({valid_o, busy_o, done_o} !== 3'b000) begin
      bad++;
      $display("FAIL abort_idle got v/b/d=%b want 000", {valid_o, busy_o, done_o});
    end
  endtask

  task automatic test_reset_mid();
    en_i = 1'b1;
    start_sweep(47'd100, 47'd10, 47'd5, 32'd5);
    tick();
    tick();
    total++;
    if (phase_o !== 47'd105) begin
      bad++;
      $display("FAIL rmid_pre got=%0d want=105", phase_o);
    end
    resetn = 1'b0;
    #1;
    total++;
    if ({valid_o, busy_o, done_o} !== 3'b000 || phase_o !== '0) begin
      bad++;
      $display("FAIL rmid_async got v/b/d=%b ph=%0d want 000 0", {valid_o, busy_o, done_o}, phase_o);
    end
`ifdef NCO_COS_EN
    total++;
    if (phase_cos_o !== P45) begin
      bad++;
      $display("FAIL rmid_cos got=%0h want=%0h", phase_cos_o, P45);
    end
`endif
    #15;
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if ({valid_o, busy_o, done_o} !== 3'b000) begin
        bad++;
        $display("FAIL rmid_post[%0d] got v/b/d=%b want 000", i, {valid_o, busy_o, done_o});
      end
    end
  endtask

  initial begin
    test_reset();
    test_fixed_tone();
    test_chirp();
    test_wrap();
    test_en_gating();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
